// File: rtl/operand_issue_stage.sv
// Decode->execute boundary register: operand capture, valid/ready issue,
// and load-use hazard bubbling against the instruction held in execute.
module operand_issue_stage #(
  parameter int unsigned REGI_BITS = 4,
  parameter int unsigned REGI_SIZE = 16,
  parameter int unsigned OPC_BITS  = 4,
  parameter int unsigned LOAD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [OPC_BITS-1:0]  id_opcode,
  input  logic [REGI_BITS-1:0] id_ra1,
  input  logic [REGI_BITS-1:0] id_ra2,
  input  logic [REGI_BITS-1:0] id_wa,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic [REGI_SIZE-1:0] id_imm,
  input  logic [REGI_SIZE-1:0] id_pc,
  output logic [REGI_BITS-1:0] rf_ra1,
  output logic [REGI_BITS-1:0] rf_ra2,
  input  logic [REGI_SIZE-1:0] rf_rd1,
  input  logic [REGI_SIZE-1:0] rf_rd2,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [OPC_BITS-1:0]  ex_opcode,
  output logic [REGI_BITS-1:0] ex_wa,
  output logic                 ex_we,
  output logic                 ex_is_load,
  output logic [REGI_SIZE-1:0] ex_imm,
  output logic [REGI_SIZE-1:0] ex_pc,
  output logic [REGI_SIZE-1:0] ex_op1,
  output logic [REGI_SIZE-1:0] ex_op2
);

  localparam int unsigned CNT_BITS = $clog2(LOAD_LAT + 1);

  typedef enum logic {ST_RUN, ST_HAZ} state_t;

  typedef struct packed {
    logic [OPC_BITS-1:0]  opcode;
    logic [REGI_BITS-1:0] wa;
    logic                 we;
    logic                 is_load;
    logic [REGI_SIZE-1:0] imm;
    logic [REGI_SIZE-1:0] pc;
    logic [REGI_SIZE-1:0] op1;
    logic [REGI_SIZE-1:0] op2;
  } ex_pl_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ex_valid_q, ex_valid_d;
  ex_pl_t              ex_q, ex_d;

  logic dep;
  logic accept;
  logic ex_xfer;

  // Register-file read addresses follow decode directly.
  assign rf_ra1 = id_ra1;
  assign rf_ra2 = id_ra2;

  // Load-use dependency of the decoded instruction on the load held in execute.
  always_comb begin
    dep = ex_valid_q & ex_q.is_load & ex_q.we & (ex_q.wa != '0) &
          (((id_ra1 == ex_q.wa) & (id_ra1 != '0)) |
           ((id_ra2 == ex_q.wa) & (id_ra2 != '0)));
  end

  // Handshake qualifiers.
  always_comb begin
    id_ready = (state_q == ST_RUN) & ~flush & ~(id_valid & dep) &
               (~ex_valid_q | ex_ready);
    accept   = id_valid & id_ready;
    ex_xfer  = ex_valid_q & ex_ready;
  end

  // Next-state: issue register, hazard state and bubble counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      state_d    = ST_RUN;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            ex_d.opcode  = id_opcode;
            ex_d.wa      = id_wa;
            ex_d.we      = id_we;
            ex_d.is_load = id_is_load;
            ex_d.imm     = id_imm;
            ex_d.pc      = id_pc;
            ex_d.op1     = rf_rd1;
            ex_d.op2     = rf_rd2;
            ex_valid_d   = 1'b1;
          end else if (ex_xfer) begin
            ex_valid_d = 1'b0;
            if (id_valid & dep) begin
              state_d = ST_HAZ;
              cnt_d   = CNT_BITS'(LOAD_LAT - 1);
            end
          end
        end
        ST_HAZ: begin
          ex_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and execute-side register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opcode  = ex_q.opcode;
  assign ex_wa      = ex_q.wa;
  assign ex_we      = ex_q.we;
  assign ex_is_load = ex_q.is_load;
  assign ex_imm     = ex_q.imm;
  assign ex_pc      = ex_q.pc;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage with a small register-file model.
module tb_operand_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [3:0]  id_opcode, id_ra1, id_ra2, id_wa;
  logic        id_we, id_is_load;
  logic [15:0] id_imm, id_pc;
  logic [3:0]  rf_ra1, rf_ra2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_opcode, ex_wa;
  logic        ex_we, ex_is_load;
  logic [15:0] ex_imm, ex_pc, ex_op1, ex_op2;

  logic [15:0] rf [16];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Register file: address 0 reads zero.
  always_comb begin
    rf_rd1 = (rf_ra1 == 4'd0) ? 16'h0 : rf[rf_ra1];
    rf_rd2 = (rf_ra2 == 4'd0) ? 16'h0 : rf[rf_ra2];
  end

  operand_issue_stage #(.REGI_BITS(4), .REGI_SIZE(16), .OPC_BITS(4), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_ra1(id_ra1), .id_ra2(id_ra2), .id_wa(id_wa),
    .id_we(id_we), .id_is_load(id_is_load), .id_imm(id_imm), .id_pc(id_pc),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_wa(ex_wa), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] opc, input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic [3:0] wa, input logic we, input logic ld,
                        input logic [15:0] imm, input logic [15:0] pc);
    id_opcode = opc; id_ra1 = ra1; id_ra2 = ra2; id_wa = wa;
    id_we = we; id_is_load = ld; id_imm = imm; id_pc = pc;
    id_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    set_id(4'hF, 4'h3, 4'h4, 4'h9, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    tick(); tick();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_checks++;
    if ({ex_opcode, ex_wa, ex_we, ex_is_load, ex_imm, ex_pc, ex_op1, ex_op2} !== 74'd0) begin
      n_fails++; $display("FAIL reset_fields pc=%h op1=%h wa=%h want all 0", ex_pc, ex_op1, ex_wa);
    end
    rst_n = 1'b1; id_valid = 1'b0;
    #1;
    n_checks++;
    if (rf_ra1 !== 4'h3 || rf_ra2 !== 4'h4) begin
      n_fails++; $display("FAIL rf_addr got %h/%h want 3/4", rf_ra1, rf_ra2);
    end
  endtask

  task automatic test_basic_issue();
    set_id(4'h1, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 16'h0007, 16'h0100);
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fails++; $display("FAIL basic_ready got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 16'h1234 || ex_op2 !== 16'h0042 ||
        ex_wa !== 4'd5 || ex_pc !== 16'h0100 || ex_imm !== 16'h0007 || ex_opcode !== 4'h1) begin
      n_fails++;
      $display("FAIL basic_issue v=%b op1=%h op2=%h wa=%h pc=%h want 1 1234 0042 5 0100",
               ex_valid, ex_op1, ex_op2, ex_wa, ex_pc);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_op1 !== 16'h1234) begin
      n_fails++; $display("FAIL drain v=%b op1=%h want 0 1234", ex_valid, ex_op1);
    end
  endtask

  task automatic test_backpressure();
    set_id(4'h2, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 16'h0001, 16'h0200);
    tick();
    ex_ready = 1'b0;
    set_id(4'h3, 4'd4, 4'd3, 4'd7, 1'b1, 1'b0, 16'h0002, 16'h0204);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin n_fails++; $display("FAIL bp_ready[%0d] got %b want 0", i, id_ready); end
      tick();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 16'h0200 || ex_op1 !== 16'h1234 || ex_op2 !== 16'h0000) begin
        n_fails++; $display("FAIL bp_hold[%0d] v=%b pc=%h op1=%h want 1 0200 1234", i, ex_valid, ex_pc, ex_op1);
      end
    end
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 16'h0204 || ex_op1 !== 16'h0042 || ex_op2 !== 16'h1234) begin
      n_fails++; $display("FAIL bp_next v=%b pc=%h op1=%h want 1 0204 0042", ex_valid, ex_pc, ex_op1);
    end
    tick();
  endtask

  task automatic test_load_use();
    rf[2] = 16'h1111; rf[1] = 16'h0005;
    set_id(4'h8, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0010, 16'h0300);
    tick();
    set_id(4'h1, 4'd2, 4'd1, 4'd6, 1'b1, 1'b0, 16'h0000, 16'h0302);
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin n_fails++; $display("FAIL lu_dep_ready got %b want 0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) rf[2] = 16'hBEEF;
      n_checks++;
      if (ex_valid !== 1'b0) begin n_fails++; $display("FAIL lu_bubble[%0d] got %b want 0", i, ex_valid); end
      n_checks++;
      if (id_ready !== (i == 2)) begin
        n_fails++; $display("FAIL lu_ready[%0d] got %b want %b", i, id_ready, (i == 2));
      end
    end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 16'hBEEF || ex_op2 !== 16'h0005 || ex_pc !== 16'h0302) begin
      n_fails++; $display("FAIL lu_issue v=%b op1=%h op2=%h pc=%h want 1 BEEF 0005 0302",
                          ex_valid, ex_op1, ex_op2, ex_pc);
    end
    tick();
  endtask

  task automatic test_reg0();
    set_id(4'h8, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0000, 16'h0400);
    tick();
    set_id(4'h1, 4'd0, 4'd3, 4'd8, 1'b1, 1'b0, 16'h0000, 16'h0402);
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fails++; $display("FAIL r0_ready got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 16'h0000 || ex_op2 !== 16'h1234 || ex_pc !== 16'h0402) begin
      n_fails++; $display("FAIL r0_issue v=%b op1=%h op2=%h pc=%h want 1 0000 1234 0402",
                          ex_valid, ex_op1, ex_op2, ex_pc);
    end
    tick();
  endtask

  task automatic test_flush();
    rf[15] = 16'h0F0F;
    set_id(4'h8, 4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 16'h0000, 16'h0500);
    tick();
    set_id(4'h1, 4'd15, 4'd0, 4'd9, 1'b1, 1'b0, 16'h0000, 16'h0502);
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin n_fails++; $display("FAIL r15_dep got %b want 0", id_ready); end
    tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin n_fails++; $display("FAIL flush_ready got %b want 0", id_ready); end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      n_fails++; $display("FAIL flush_run v=%b rdy=%b want 0 1", ex_valid, id_ready);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 16'h0502 || ex_op1 !== 16'h0F0F) begin
      n_fails++; $display("FAIL flush_issue v=%b pc=%h op1=%h want 1 0502 0F0F", ex_valid, ex_pc, ex_op1);
    end
    set_id(4'h4, 4'd1, 4'd1, 4'd3, 1'b1, 1'b0, 16'h0000, 16'h0504);
    flush = 1'b1;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_pc !== 16'h0502) begin
      n_fails++; $display("FAIL flush_kill v=%b pc=%h want 0 0502", ex_valid, ex_pc);
    end
  endtask

  task automatic test_reset_in_haz();
    rf[7] = 16'h0777;
    set_id(4'hA, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 16'h00AA, 16'h0600);
    tick();
    set_id(4'h1, 4'd0, 4'd7, 4'd9, 1'b1, 1'b0, 16'h0000, 16'h0602);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({ex_valid, ex_opcode, ex_wa, ex_we, ex_is_load, ex_imm, ex_pc, ex_op1, ex_op2} !== 75'd0) begin
      n_fails++; $display("FAIL rst_haz v=%b opc=%h wa=%h imm=%h pc=%h want all 0",
                          ex_valid, ex_opcode, ex_wa, ex_imm, ex_pc);
    end
    n_checks++;
    if (id_ready !== 1'b1) begin n_fails++; $display("FAIL rst_haz_ready got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 16'h0602 || ex_op2 !== 16'h0777) begin
      n_fails++; $display("FAIL rst_resume v=%b pc=%h op2=%h want 1 0602 0777", ex_valid, ex_pc, ex_op2);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    rf[3] = 16'h1234;
    rf[4] = 16'h0042;
    #2;
    test_reset();
    test_basic_issue();
    test_backpressure();
    test_load_use();
    test_reg0();
    test_flush();
    test_reset_in_haz();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
